// File: rtl/approx_add_pipe.sv
// Pipelined adder with run-time selectable lower-part-OR approximation and valid/ready handshake.
// Define APPROX_ADD_ERR_STAT_EN to build the exact shadow path and error statistics.
module approx_add_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 2,
  parameter int unsigned STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  input  logic             stat_clr,
  output logic [31:0]      err_cnt,
  output logic [WIDTH:0]   err_max,
  output logic [31:0]      err_sum
);

  logic [WIDTH:0]    exact_sum;
  logic [WIDTH:0]    calc_sum;
  logic [STAGES-1:0] v_q;
  logic [WIDTH:0]    sum_q [STAGES];
  logic [STAGES-1:0] rdy;

  assign exact_sum = {1'b0, a} + {1'b0, b};

  if (APPROX_BITS > 0) begin : g_approx
    localparam int unsigned UW = WIDTH - APPROX_BITS + 1;
    logic [UW-1:0] upper;
    logic          carry;
    // Only the top approximated bit pair feeds a carry into the exact upper part.
    assign carry = a[APPROX_BITS-1] & b[APPROX_BITS-1];
    assign upper = {1'b0, a[WIDTH-1:APPROX_BITS]} + {1'b0, b[WIDTH-1:APPROX_BITS]}
                 + {{(UW-1){1'b0}}, carry};
    assign calc_sum = approx_en ? {upper, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]} : exact_sum;
  end else begin : g_exact
    logic unused_approx_en;
    assign unused_approx_en = approx_en;
    assign calc_sum = exact_sum;
  end

  // A slice may load when it or any slice downstream of it has room, or the sink accepts.
  always_comb begin
    logic r;
    rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      r = out_ready;
      for (int j = i; j < STAGES; j++) r = r | ~v_q[j];
      rdy[i] = r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) sum_q[i] <= '0;
    end else begin
      if (rdy[0]) begin
        v_q[0]   <= in_valid;
        sum_q[0] <= calc_sum;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          v_q[i]   <= v_q[i-1];
          sum_q[i] <= sum_q[i-1];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];

`ifdef APPROX_ADD_ERR_STAT_EN
  logic [WIDTH:0] exact_q [STAGES];
  logic           deliver;
  logic [WIDTH:0] exact_out;
  logic [WIDTH:0] err_abs;
  logic [32:0]    esum_wide;
  logic [31:0]    err_cnt_q, err_cnt_d;
  logic [31:0]    err_sum_q, err_sum_d;
  logic [WIDTH:0] err_max_q, err_max_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) exact_q[i] <= '0;
    end else begin
      if (rdy[0]) exact_q[0] <= exact_sum;
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) exact_q[i] <= exact_q[i-1];
      end
    end
  end

  assign deliver   = out_valid & out_ready;
  assign exact_out = exact_q[STAGES-1];
  assign err_abs   = (sum >= exact_out) ? (sum - exact_out) : (exact_out - sum);
  assign esum_wide = {1'b0, err_sum_q} + 33'(err_abs);

  always_comb begin
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    // Clear takes priority over a coinciding delivery.
    if (stat_clr) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      err_max_d = '0;
    end else if (deliver) begin
      if ((err_abs != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 32'd1;
      if (err_abs > err_max_q) err_max_d = err_abs;
      err_sum_d = esum_wide[32] ? '1 : esum_wide[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
  assign err_sum = err_sum_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign err_cnt = '0;
  assign err_max = '0;
  assign err_sum = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed self-checking bench for approx_add_pipe: default build (8/2/2) plus a 16-bit,
// exact-only, 4-stage instance.
module tb_approx_add_pipe;

`ifdef APPROX_ADD_ERR_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  a = '0, b = '0;
  logic        approx_en = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [8:0]  sum;
  logic        stat_clr = 1'b0;
  logic [31:0] err_cnt, err_sum;
  logic [8:0]  err_max;

  logic        w_in_valid = 1'b0, w_in_ready;
  logic [15:0] w_a = '0, w_b = '0;
  logic        w_approx_en = 1'b0;
  logic        w_out_valid, w_out_ready = 1'b0;
  logic [16:0] w_sum;
  logic        w_stat_clr = 1'b0;
  logic [31:0] w_err_cnt, w_err_sum;
  logic [16:0] w_err_max;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .stat_clr(stat_clr), .err_cnt(err_cnt), .err_max(err_max), .err_sum(err_sum)
  );

  approx_add_pipe #(.WIDTH(16), .APPROX_BITS(0), .STAGES(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .approx_en(w_approx_en), .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
    .stat_clr(w_stat_clr), .err_cnt(w_err_cnt), .err_max(w_err_max), .err_sum(w_err_sum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] c, input logic [8:0] m,
                           input logic [31:0] s);
    chk({tag, "_cnt"}, err_cnt, Stat ? c : 32'd0);
    chk({tag, "_max"}, err_max, Stat ? m : 9'd0);
    chk({tag, "_esum"}, err_sum, Stat ? s : 32'd0);
  endtask

  // Present one beat with out_ready=1; result must appear exactly two cycles later.
  task automatic xact(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic ten, input logic [8:0] exp);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; approx_en = ten; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, exp);
  endtask

  logic [8:0] b2b_exp [16] = '{9'd0, 9'd1, 9'd6, 9'd7, 9'd8, 9'd9, 9'd14, 9'd15,
                               9'd16, 9'd17, 9'd22, 9'd23, 9'd24, 9'd25, 9'd30, 9'd31};
  logic [3:0] pat = 4'b1001;

  initial begin
    int sent;
    int rcv;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 9'h000);
    chk_stats("rst", 32'd0, 9'd0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Basic approximate / exact cases
    xact("t1", 8'h02, 8'h02, 1'b1, 9'h006);
    @(negedge clk);
    chk("t1_drained", out_valid, 1'b0);
    chk_stats("t1", 32'd1, 9'd2, 32'd2);
    xact("t2a", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    xact("t2e", 8'hFF, 8'hFF, 1'b0, 9'h1FE);
    @(negedge clk);
    chk_stats("t2", 32'd2, 9'd2, 32'd3);
    xact("t3a", 8'h03, 8'h01, 1'b1, 9'h003);
    xact("t3b", 8'h10, 8'h20, 1'b1, 9'h030);
    @(negedge clk);
    chk_stats("t3", 32'd3, 9'd2, 32'd4);

    // Clear coinciding with a delivery: clear wins, beat not counted
    xact("clr", 8'h03, 8'h01, 1'b1, 9'h003);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk_stats("clr", 32'd0, 9'd0, 32'd0);
    xact("post_clr", 8'h02, 8'h02, 1'b1, 9'h006);
    @(negedge clk);
    chk_stats("post_clr", 32'd1, 9'd2, 32'd2);

    // Back-to-back 16 beats with out_ready pattern 1,0,0,1
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 200 && rcv < 16; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 16);
      a = 8'(sent);
      b = 8'(sent);
      approx_en = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("b2b_%0d", rcv), sum, b2b_exp[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("b2b_rcv_count", rcv, 16);
    chk("b2b_sent_count", sent, 16);

    // Stall: two held beats fill the pipe and drop in_ready
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h10; b = 8'h10; approx_en = 1'b1;
    #1 chk("stall_rdy0", in_ready, 1'b1);
    @(negedge clk);
    a = 8'h20; b = 8'h20;
    #1 chk("stall_rdy1", in_ready, 1'b1);
    @(negedge clk);
    a = 8'h30; b = 8'h30;
    #1 chk("stall_full", in_ready, 1'b0);
    chk("stall_sum0", sum, 9'h020);
    @(negedge clk);
    chk("stall_hold_rdy", in_ready, 1'b0);
    chk("stall_hold_sum", sum, 9'h020);
    out_ready = 1'b1;
    #1 chk("stall_release", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_sum1", sum, 9'h040);
    @(negedge clk);
    chk("stall_sum2", sum, 9'h060);
    @(negedge clk);
    chk("stall_empty", out_valid, 1'b0);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h03; b = 8'h01;
    @(negedge clk);
    a = 8'h02; b = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_inflight", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 9'h000);
    chk_stats("mid_rst", 32'd0, 9'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact("after_rst", 8'h10, 8'h20, 1'b1, 9'h030);
    @(negedge clk);
    chk("after_rst_empty", out_valid, 1'b0);
    chk_stats("after_rst", 32'd0, 9'd0, 32'd0);

    // Wide exact-only instance: carry-out and 4-cycle latency
    @(negedge clk);
    w_in_valid = 1'b1; w_a = 16'hFFFF; w_b = 16'h0001; w_approx_en = 1'b1; w_out_ready = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("w_lat1", w_out_valid, 1'b0);
    @(negedge clk);
    chk("w_lat2", w_out_valid, 1'b0);
    @(negedge clk);
    chk("w_lat3", w_out_valid, 1'b0);
    @(negedge clk);
    chk("w_valid", w_out_valid, 1'b1);
    chk("w_sum", w_sum, 17'h10000);
    @(negedge clk);
    chk("w_drained", w_out_valid, 1'b0);
    chk("w_err_cnt", w_err_cnt, 32'd0);
    chk("w_err_max", w_err_max, 17'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
